fpu_result_buffer: RTL

- Downstream neighbour of the FPU wrapper.
- Captures single-cycle result pulses (result, status flags, tag) into a DEPTH-entry queue and presents them to writeback with a valid/ready handshake.
- Issues credits upstream so the FPU is never given an op whose result cannot be stored.
- Discards results of ops that were in flight at a flush, and accumulates sticky fflags.

---
 rtl/fpu_resbuf_pkg.sv | 25 ++
 rtl/fpu_result_buffer_if.sv | 31 +++
 rtl/fpu_resbuf_credit.sv | 83 ++++++++
 rtl/fpu_result_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_resbuf_pkg.sv
// Shared types and sizing helpers for the FPU result buffer.
package fpu_resbuf_pkg;

  localparam int unsigned STATUS_W = 5;

  // IEEE exception flags as reported by the FPU, MSB first.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a queue pointer; a single-entry queue still gets one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fpu_result_buffer_if.sv
// Result-in / writeback-out bundle of the FPU result buffer.
// The buffer connects through the slave modport, its environment through master.
interface fpu_result_buffer_if
  import fpu_resbuf_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter type         TagType = logic
) ();

  logic             res_valid_i;
  logic [WIDTH-1:0] res_data_i;
  status_t          res_status_i;
  TagType           res_tag_i;

  logic             wb_valid_o;
  logic             wb_ready_i;
  logic [WIDTH-1:0] wb_result_o;
  status_t          wb_status_o;
  TagType           wb_tag_o;

  modport slave (
    input  res_valid_i, res_data_i, res_status_i, res_tag_i, wb_ready_i,
    output wb_valid_o, wb_result_o, wb_status_o, wb_tag_o
  );

  modport master (
    output res_valid_i, res_data_i, res_status_i, res_tag_i, wb_ready_i,
    input  wb_valid_o, wb_result_o, wb_status_o, wb_tag_o
  );

endinterface

// File: rtl/fpu_resbuf_credit.sv
// Credit tracker: counts ops in flight (outs) and ops whose results must be
// discarded after a flush (drop); decides the fate of every result pulse.
module fpu_resbuf_credit
  import fpu_resbuf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_issue,
  input  logic             i_res_valid,
  input  logic [CNT_W-1:0] i_count,
  output logic             o_issue_ready_c,
  output logic             o_push_c,
  output logic             o_spurious_c,
  output logic             o_flush_drop_c
);

  localparam int unsigned SUM_W = CNT_W + 2;

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t             r_outs;
  cnt_t             r_drop;
  cnt_t             w_outs_next;
  cnt_t             w_drop_next;
  cnt_t             w_outs_int;
  cnt_t             w_drop_int;
  logic [SUM_W-1:0] w_total;

  // A credit exists while stored + in-flight + to-be-dropped stays below DEPTH.
  assign w_total         = SUM_W'(i_count) + SUM_W'(r_outs) + SUM_W'(r_drop);
  assign o_issue_ready_c = (w_total < SUM_W'(DEPTH));

  // Charge each result to drop first, then to outs; flush folds outs into drop.
  always_comb begin
    o_push_c       = 1'b0;
    o_spurious_c   = 1'b0;
    o_flush_drop_c = 1'b0;
    w_outs_int     = r_outs;
    w_drop_int     = r_drop;
    w_outs_next    = r_outs;
    w_drop_next    = r_drop;

    if (i_res_valid) begin
      if (r_drop != '0) begin
        w_drop_int     = r_drop - CNT_W'(1);
        o_flush_drop_c = 1'b1;
      end else if (r_outs != '0) begin
        w_outs_int = r_outs - CNT_W'(1);
        if (i_flush) begin
          o_flush_drop_c = 1'b1;
        end else begin
          o_push_c = 1'b1;
        end
      end else if (!i_flush) begin
        o_spurious_c = 1'b1;
      end
    end

    if (i_flush) begin
      w_drop_next = w_drop_int + w_outs_int;
      w_outs_next = '0;
    end else begin
      w_drop_next = w_drop_int;
      w_outs_next = w_outs_int + CNT_W'(i_issue && o_issue_ready_c);
    end
  end

  // Counter state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outs <= '0;
      r_drop <= '0;
    end else begin
      r_outs <= w_outs_next;
      r_drop <= w_drop_next;
    end
  end

endmodule

// File: rtl/fpu_result_buffer.sv
// FPU result buffer: queues single-cycle FPU result pulses for writeback,
// grants issue credits, drops results squashed by flush, keeps sticky fflags.
// Optional statistics outputs are enabled with the FPU_RESBUF_STATS_EN macro.
module fpu_result_buffer
  import fpu_resbuf_pkg::*;
#(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned DEPTH   = 4,
  parameter type         TagType = logic
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                issue_i,
  output logic                                issue_ready_o,
  fpu_result_buffer_if.slave                  bus,
  output status_t                             fflags_o,
  input  logic                                fflags_clr_i,
  output logic                                overflow_err_o
`ifdef FPU_RESBUF_STATS_EN
  ,
  output logic [15:0]                         stat_dropped_o,
  output logic [cnt_width(DEPTH)-1:0]         stat_maxocc_o
`endif
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    status_t          status;
    TagType           tag;
  } resbuf_entry_t;

  resbuf_entry_t r_mem [DEPTH];
  ptr_t          r_head;
  ptr_t          r_tail;
  cnt_t          r_count;
  cnt_t          w_count_next;
  status_t       r_fflags;
  status_t       w_fflags_next;
  logic          r_overflow;
  logic          w_push;
  logic          w_pop;
  logic          w_spurious;
  logic          w_flush_drop;
  logic          w_issue_ready;
  resbuf_entry_t w_head;
  resbuf_entry_t w_in;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  fpu_resbuf_credit #(
    .DEPTH (DEPTH)
  ) u_credit (
    .i_clk           (clk_i),
    .i_rst_n         (rst_ni),
    .i_flush         (flush_i),
    .i_issue         (issue_i),
    .i_res_valid     (bus.res_valid_i),
    .i_count         (r_count),
    .o_issue_ready_c (w_issue_ready),
    .o_push_c        (w_push),
    .o_spurious_c    (w_spurious),
    .o_flush_drop_c  (w_flush_drop)
  );

  assign issue_ready_o = w_issue_ready;

  assign w_in.result = bus.res_data_i;
  assign w_in.status = bus.res_status_i;
  assign w_in.tag    = bus.res_tag_i;

  assign w_head           = r_mem[r_head];
  assign bus.wb_valid_o   = (r_count != '0);
  assign bus.wb_result_o  = w_head.result;
  assign bus.wb_status_o  = w_head.status;
  assign bus.wb_tag_o     = w_head.tag;
  assign fflags_o         = r_fflags;
  assign overflow_err_o   = r_overflow;

  // A pop offered during flush is squashed along with the queue.
  assign w_pop = bus.wb_valid_o && bus.wb_ready_i && !flush_i;

  // Occupancy update; push and pop together leave count unchanged.
  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CNT_W'(1);
        2'b01:   w_count_next = r_count - CNT_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  // Queue storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
      if (flush_i) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= w_in;
          r_tail        <= ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= ptr_inc(r_head);
        end
      end
    end
  end

  // Sticky flags: clear takes effect before the popped status is ORed in.
  always_comb begin
    w_fflags_next = fflags_clr_i ? status_t'('0) : r_fflags;
    if (w_pop) begin
      w_fflags_next = status_t'(w_fflags_next | w_head.status);
    end
  end

  // Sticky flag and overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fflags   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_fflags <= w_fflags_next;
      if (w_spurious) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef FPU_RESBUF_STATS_EN
  logic [15:0] r_stat_dropped;
  cnt_t        r_stat_maxocc;

  assign stat_dropped_o = r_stat_dropped;
  assign stat_maxocc_o  = r_stat_maxocc;

  // Saturating flush-drop count and occupancy high-water mark; flush keeps both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_dropped <= '0;
      r_stat_maxocc  <= '0;
    end else begin
      if (w_flush_drop && (r_stat_dropped != 16'hFFFF)) begin
        r_stat_dropped <= r_stat_dropped + 16'd1;
      end
      if (w_count_next > r_stat_maxocc) begin
        r_stat_maxocc <= w_count_next;
      end
    end
  end
`else
  logic w_unused_flush_drop;
  assign w_unused_flush_drop = w_flush_drop;
`endif

  // Issuing without a credit is an upstream protocol violation.
  a_issue_has_credit : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (issue_i && !flush_i) |-> w_issue_ready
  );

endmodule
